// File: rtl/cadder_sweep_checker.sv
// cadder_sweep_checker: drives every A/B operand pair into a clocked adder once
// and checks each returned Z against A+B, LATENCY edges after the adder samples.
module cadder_sweep_checker #(
  parameter int WIDTH     = 4,
  parameter int LATENCY   = 1,
  parameter int ERR_CNT_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  input  logic [WIDTH:0]       Z,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_err_a,
  output logic [WIDTH-1:0]     first_err_b,
  output logic [WIDTH:0]       first_err_z
);

  localparam int CNT_W   = 2 * WIDTH;
  localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } slot_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  slot_t [LATENCY-1:0]  dl;
  slot_t                push;
  slot_t                head;
  logic                 last_vec;
  logic                 drain_last;
  logic                 sweep_start;
  logic                 mismatch;
  logic                 err_sat;

  // Operands come straight from the vector counter flops, so they are registered.
  assign A = cnt[WIDTH-1:0];
  assign B = cnt[CNT_W-1:WIDTH];

  assign last_vec    = (cnt == '1);
  assign drain_last  = (drain_cnt == DRAIN_W'(LATENCY - 1));
  assign sweep_start = start && ((state == IDLE) || (state == DONE));
  assign head        = dl[LATENCY-1];
  assign mismatch    = head.valid && (Z != head.sum);
  assign err_sat     = (err_count == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)      state_nxt = RUN;
      RUN:        if (last_vec)   state_nxt = DRAIN;
      DRAIN:      if (drain_last) state_nxt = DONE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

  // Counter holds the last vector through DRAIN and returns to 0 entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt       <= '0;
            drain_cnt <= '0;
          end
        end
        RUN: begin
          drain_cnt <= '0;
          if (!last_vec) cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          if (drain_last) cnt <= '0;
          else            drain_cnt <= drain_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    push       = '0;
    push.valid = (state == RUN);
    push.a     = A;
    push.b     = B;
    push.sum   = {1'b0, A} + {1'b0, B};
  end

  if (LATENCY == 1) begin : g_dl_single
    always_ff @(posedge clk) begin
      if (rst) dl[0] <= '0;
      else     dl[0] <= push;
    end
  end else begin : g_dl_multi
    always_ff @(posedge clk) begin
      if (rst) dl <= '0;
      else     dl <= {dl[LATENCY-2:0], push};
    end
  end

  // The final comparison lands on the DRAIN->DONE edge, so pass folds it in.
  always_ff @(posedge clk) begin
    if (rst || sweep_start) begin
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      first_err_z <= '0;
      pass        <= 1'b0;
    end else begin
      if (mismatch) begin
        if (!err_sat) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_err_a <= head.a;
          first_err_b <= head.b;
          first_err_z <= Z;
        end
      end
      if ((state == DRAIN) && drain_last) begin
        pass <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_cadder_sweep_checker.sv
// Bench for cadder_sweep_checker: four checker instances run in parallel against
// behavioural adders with selectable carry faults and random per-vector corruption.
module tb_cadder_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic [3:0] a1, b1, a2, b2, a3, b3, a4, b4;
  logic [4:0] z1, z2, z3, z4, z3_s, z4_s;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic       busy3, done3, pass3, busy4, done4, pass4;
  logic [8:0] err1, err3, err4;
  logic [5:0] err2;
  logic [3:0] fa1, fb1, fa2, fb2, fa3, fb3, fa4, fb4;
  logic [4:0] fz1, fz2, fz3, fz4;

  bit         carry_err;
  logic [4:0] flip [256];

  int          n_vec;
  int          n_bad;
  int          de1, de2, de3, de4, busy_cyc, ab_bad;
  logic [8:0]  e0_err;
  logic [12:0] e0_first;
  logic        e0_done;

  cadder_sweep_checker #(.WIDTH(4), .LATENCY(1), .ERR_CNT_W(9)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .A(a1), .B(b1), .Z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_z(fz1));

  cadder_sweep_checker #(.WIDTH(4), .LATENCY(1), .ERR_CNT_W(6)) u_w6 (
    .clk(clk), .rst(rst), .start(start), .A(a2), .B(b2), .Z(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_z(fz2));

  cadder_sweep_checker #(.WIDTH(4), .LATENCY(2), .ERR_CNT_W(9)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .A(a3), .B(b3), .Z(z3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_a(fa3), .first_err_b(fb3), .first_err_z(fz3));

  cadder_sweep_checker #(.WIDTH(4), .LATENCY(1), .ERR_CNT_W(9)) u_l2m (
    .clk(clk), .rst(rst), .start(start), .A(a4), .B(b4), .Z(z4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_err_a(fa4), .first_err_b(fb4), .first_err_z(fz4));

  function automatic logic [4:0] adder_fn(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (carry_err) s[4] = 1'b0;
    return s ^ flip[{b, a}];
  endfunction

  // u_l1/u_w6 see a one-stage adder; u_l2/u_l2m see a two-stage adder.
  always @(posedge clk) begin
    z1   <= adder_fn(a1, b1);
    z2   <= adder_fn(a2, b2);
    z3_s <= adder_fn(a3, b3);
    z3   <= z3_s;
    z4_s <= adder_fn(a4, b4);
    z4   <= z4_s;
  end

  // Reference: walk all pairs in sweep order and tally what the adder returns.
  task automatic model_sweep(output int ne, output int fa, output int fb, output int fz);
    ne = 0; fa = 0; fb = 0; fz = 0;
    for (int c = 0; c < 256; c++) begin
      int a, b, s, z;
      a = c % 16;
      b = c / 16;
      s = a + b;
      z = (carry_err ? s % 16 : s) ^ int'(flip[c]);
      if (z != s) begin
        if (ne == 0) begin fa = a; fb = b; fz = z; end
        ne++;
      end
    end
  endtask

  // Edge 0 samples start; records the edge at which each instance raises done.
  task automatic run_sweep(input int repulse_at, input int rst_at);
    logic [7:0] exp_ab;
    de1 = -1; de2 = -1; de3 = -1; de4 = -1; busy_cyc = 0; ab_bad = 0;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e < 300; e++) begin
      @(posedge clk);
      #1;
      if (e == rst_at) break;
      if (e == 0) begin e0_err = err1; e0_first = {fa1, fb1, fz1}; e0_done = done1; end
      if (busy1) busy_cyc++;
      if (done1 && de1 < 0) de1 = e;
      if (done2 && de2 < 0) de2 = e;
      if (done3 && de3 < 0) de3 = e;
      if (done4 && de4 < 0) de4 = e;
      exp_ab = (e < 256) ? 8'(e) : 8'hff;
      if (de1 < 0 && {b1, a1} !== exp_ab) ab_bad++;
      if (de1 >= 0 && de2 >= 0 && de3 >= 0 && de4 >= 0) break;
      @(negedge clk);
      start = (e + 1 == repulse_at);
      rst   = (e + 1 == rst_at);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({busy1, done1, pass1} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy1, done1, pass1}); end
    n_vec++; if (err1 !== 9'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err1); end
    n_vec++; if ({a1, b1, fa1, fb1, fz1} !== 21'd0) begin n_bad++; $display("FAIL reset_regs got %h want 0", {a1, b1, fa1, fb1, fz1}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_sweep;
    carry_err = 1'b0;
    run_sweep(-1, -1);
    n_vec++; if (de1 != 257) begin n_bad++; $display("FAIL clean_done_edge got %0d want 257", de1); end
    n_vec++; if (busy_cyc != 257) begin n_bad++; $display("FAIL clean_busy_cycles got %0d want 257", busy_cyc); end
    n_vec++; if (ab_bad != 0) begin n_bad++; $display("FAIL clean_vector_order got %0d bad want 0", ab_bad); end
    n_vec++; if (pass1 !== 1'b1 || err1 !== 9'd0) begin n_bad++; $display("FAIL clean_pass got pass=%b err=%0d want pass=1 err=0", pass1, err1); end
    n_vec++; if ({fa1, fb1, fz1} !== 13'd0) begin n_bad++; $display("FAIL clean_first_err got %h want 0", {fa1, fb1, fz1}); end
    n_vec++; if ({a1, b1} !== 8'd0) begin n_bad++; $display("FAIL clean_ab_done got %h want 00", {a1, b1}); end
    n_vec++; if (de3 != 258 || pass3 !== 1'b1) begin n_bad++; $display("FAIL lat2_done got edge=%0d pass=%b want edge=258 pass=1", de3, pass3); end
    n_vec++; if (pass4 !== 1'b0 || err4 === 9'd0) begin n_bad++; $display("FAIL lat_mismatch got pass=%b err=%0d want pass=0 err>0", pass4, err4); end
  endtask

  task automatic test_carry_error;
    carry_err = 1'b1;
    run_sweep(-1, -1);
    n_vec++; if (err1 !== 9'd120 || pass1 !== 1'b0) begin n_bad++; $display("FAIL carry_err_count got err=%0d pass=%b want err=120 pass=0", err1, pass1); end
    n_vec++; if ({fa1, fb1, fz1} !== {4'd15, 4'd1, 5'd0}) begin n_bad++; $display("FAIL carry_first got a=%0d b=%0d z=%0d want 15 1 0", fa1, fb1, fz1); end
    n_vec++; if (de1 != 257) begin n_bad++; $display("FAIL carry_done_edge got %0d want 257", de1); end
    n_vec++; if (err2 !== 6'd63 || pass2 !== 1'b0) begin n_bad++; $display("FAIL sat_count got err=%0d pass=%b want 63 0", err2, pass2); end
    n_vec++; if ({fa2, fb2, fz2} !== {4'd15, 4'd1, 5'd0}) begin n_bad++; $display("FAIL sat_first got a=%0d b=%0d z=%0d want 15 1 0", fa2, fb2, fz2); end
    n_vec++; if (err3 !== 9'd120) begin n_bad++; $display("FAIL lat2_carry got %0d want 120", err3); end
  endtask

  task automatic test_restart;
    carry_err = 1'b0;
    run_sweep(100, -1);
    n_vec++; if (e0_err !== 9'd0 || e0_first !== 13'd0 || e0_done !== 1'b0) begin n_bad++; $display("FAIL restart_clear got err=%0d first=%h done=%b want 0 0 0", e0_err, e0_first, e0_done); end
    n_vec++; if (de1 != 257) begin n_bad++; $display("FAIL restart_done_edge got %0d want 257", de1); end
    n_vec++; if (pass1 !== 1'b1 || err1 !== 9'd0) begin n_bad++; $display("FAIL restart_pass got pass=%b err=%0d want 1 0", pass1, err1); end
  endtask

  task automatic test_reset_mid;
    carry_err = 1'b1;
    run_sweep(-1, 150);
    n_vec++; if ({busy1, done1, pass1, err1} !== 12'd0) begin n_bad++; $display("FAIL midrst_status got busy=%b done=%b pass=%b err=%0d want 0", busy1, done1, pass1, err1); end
    n_vec++; if ({a1, b1, fa1, fb1, fz1} !== 21'd0) begin n_bad++; $display("FAIL midrst_regs got %h want 0", {a1, b1, fa1, fb1, fz1}); end
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_beats_start got busy=%b want 0", busy1); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    run_sweep(-1, -1);
    n_vec++; if (err1 !== 9'd120 || de1 != 257) begin n_bad++; $display("FAIL midrst_resweep got err=%0d edge=%0d want 120 257", err1, de1); end
  endtask

  task automatic test_random_faults;
    for (int it = 0; it < 4; it++) begin
      int ne, fa, fb, fz, e9, e6;
      carry_err = 1'($urandom_range(0, 1));
      for (int c = 0; c < 256; c++)
        flip[c] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      model_sweep(ne, fa, fb, fz);
      e9 = (ne > 511) ? 511 : ne;
      e6 = (ne > 63) ? 63 : ne;
      run_sweep(int'($urandom_range(1, 250)), -1);
      n_vec++; if (err1 !== 9'(e9) || pass1 !== (ne == 0)) begin n_bad++; $display("FAIL rand%0d_l1 got err=%0d pass=%b want err=%0d", it, err1, pass1, e9); end
      n_vec++; if ({fa1, fb1, fz1} !== {4'(fa), 4'(fb), 5'(fz)}) begin n_bad++; $display("FAIL rand%0d_first got %0d %0d %0d want %0d %0d %0d", it, fa1, fb1, fz1, fa, fb, fz); end
      n_vec++; if (err2 !== 6'(e6) || {fa2, fb2, fz2} !== {4'(fa), 4'(fb), 5'(fz)}) begin n_bad++; $display("FAIL rand%0d_w6 got err=%0d want %0d", it, err2, e6); end
      n_vec++; if (err3 !== 9'(e9) || {fa3, fb3, fz3} !== {4'(fa), 4'(fb), 5'(fz)}) begin n_bad++; $display("FAIL rand%0d_l2 got err=%0d want %0d", it, err3, e9); end
      n_vec++; if (de1 != 257 || de3 != 258) begin n_bad++; $display("FAIL rand%0d_done got %0d %0d want 257 258", it, de1, de3); end
    end
    for (int c = 0; c < 256; c++) flip[c] = 5'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    carry_err = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    for (int c = 0; c < 256; c++) flip[c] = 5'd0;
    test_reset;
    test_clean_sweep;
    test_carry_error;
    test_restart;
    test_reset_mid;
    test_random_faults;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
